// File: rtl/fm_demod_zc.sv
// ---------------------------------------------------------------------------
// fm_demod_zc
// Zero-crossing FM demodulator. It tracks the IF carrier with a hysteresis
// comparator and measures the clk count between rising crossings. It averages
// the last 2**AVG_LOG2 periods and maps the deviation of that average from
// NOM_PERIOD onto an offset-binary baseband word centred at 2047.
//
// Ports
//   clk          in   sample clock (one din per clk)
//   rst          in   asynchronous reset, active low
//   din          in   12b IF sample, offset binary
//   demod_data   out  12b demodulated word, 2047 = no deviation
//   demod_valid  out  1-clk pulse when demod_data updates
//   carrier_lock out  carrier present and stable
//   period_out   out  8b last accepted period in clks
// ---------------------------------------------------------------------------
module fm_demod_zc #(
    parameter int MID        = 2048,
    parameter int HYST       = 64,
    parameter int NOM_PERIOD = 120,
    parameter int MIN_PERIOD = 60,
    parameter int MAX_PERIOD = 240,
    parameter int AVG_LOG2   = 2,
    parameter int GAIN       = 64,
    parameter int LOCK_CNT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] din,
    output logic [11:0] demod_data,
    output logic        demod_valid,
    output logic        carrier_lock,
    output logic [7:0]  period_out
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = AVG_LOG2 + 8;
    localparam int FW    = AVG_LOG2 + 1;
    localparam int LW    = $clog2(LOCK_CNT + 1);
    localparam logic [11:0] TH_HI = 12'(MID + HYST);
    localparam logic [11:0] TH_LO = 12'(MID - HYST);

    typedef enum logic {S_LOW, S_HIGH} state_t;

    logic [11:0]                 r_din;
    state_t                      r_state;
    logic [7:0]                  r_cnt;
    logic                        r_armed;
    logic [7:0]                  r_per;
    logic [3:0]                  r_vld_pipe;   // [0] period captured .. [3] output word
    logic [DEPTH-1:0][7:0]       r_win;
    logic [SW-1:0]               r_sum;
    logic [FW-1:0]               r_fill;
    logic [LW-1:0]               r_lcnt;
    logic signed [23:0]          r_prod;

    logic                        w_rise;
    logic [8:0]                  w_per;
    logic                        w_per_bad;
    logic                        w_timeout;
    logic                        w_loss;
    logic                        w_accept;
    logic [FW-1:0]               w_fill_nxt;
    logic [LW-1:0]               w_lcnt_nxt;
    logic signed [23:0]          w_diff;
    logic signed [23:0]          w_prod;
    logic signed [24:0]          w_y;

    // Only the low-to-high transition is an event; the band between the two
    // thresholds never moves the comparator.
    assign w_rise = (r_state == S_LOW) && (r_din >= TH_HI);

    // Counter holds clks since the previous rise edge, so the period is cnt+1.
    assign w_per     = {1'b0, r_cnt} + 9'd1;
    assign w_per_bad = (w_per < 9'(MIN_PERIOD)) || (w_per > 9'(MAX_PERIOD));
    assign w_timeout = r_armed && !w_rise && (r_cnt >= 8'(MAX_PERIOD));
    assign w_loss    = w_timeout || (w_rise && r_armed && w_per_bad);
    assign w_accept  = w_rise && r_armed && !w_per_bad;

    assign w_fill_nxt = (r_fill == FW'(DEPTH)) ? r_fill : r_fill + FW'(1);
    assign w_lcnt_nxt = (r_lcnt == LW'(LOCK_CNT)) ? r_lcnt : r_lcnt + LW'(1);

    assign w_diff = $signed(24'(NOM_PERIOD * DEPTH)) - $signed(24'(r_sum));
    assign w_prod = w_diff * $signed(24'(GAIN));
    assign w_y    = 25'sd2047 + ($signed({r_prod[23], r_prod}) >>> AVG_LOG2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOW;
        end else begin
            case (r_state)
                S_LOW:   if (r_din >= TH_HI) r_state <= S_HIGH;
                S_HIGH:  if (r_din <= TH_LO) r_state <= S_LOW;
                default: r_state <= S_LOW;
            endcase
        end
    end

    // Input register, period counter, arming and period capture (stage 1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_din   <= 12'd0;
            r_cnt   <= 8'd0;
            r_armed <= 1'b0;
            r_per   <= 8'd0;
        end else begin
            r_din <= din;
            if (w_rise)              r_cnt <= 8'd0;
            else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            // An out-of-range edge keeps the block armed: it starts the next period.
            if (w_rise)         r_armed <= 1'b1;
            else if (w_timeout) r_armed <= 1'b0;
            if (w_accept)       r_per   <= w_per[7:0];
        end
    end

    // Averaging window, lock tracking and output stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_pipe   <= '0;
            r_win        <= '0;
            r_sum        <= '0;
            r_fill       <= '0;
            r_lcnt       <= '0;
            r_prod       <= '0;
            carrier_lock <= 1'b0;
            period_out   <= 8'd0;
            demod_data   <= 12'd2047;
        end else if (w_loss) begin
            r_vld_pipe   <= '0;
            r_win        <= '0;
            r_sum        <= '0;
            r_fill       <= '0;
            r_lcnt       <= '0;
            carrier_lock <= 1'b0;
            demod_data   <= 12'd2047;
        end else begin
            r_vld_pipe[0] <= w_accept;
            r_vld_pipe[1] <= r_vld_pipe[0] && (w_fill_nxt == FW'(DEPTH));
            r_vld_pipe[2] <= r_vld_pipe[1];
            r_vld_pipe[3] <= r_vld_pipe[2];
            if (r_vld_pipe[0]) begin
                r_win[0] <= r_per;
                for (int i = 1; i < DEPTH; i++) r_win[i] <= r_win[i-1];
                r_sum      <= r_sum + SW'(r_per) - SW'(r_win[DEPTH-1]);
                r_fill     <= w_fill_nxt;
                r_lcnt     <= w_lcnt_nxt;
                period_out <= r_per;
                if ((w_lcnt_nxt == LW'(LOCK_CNT)) && (w_fill_nxt == FW'(DEPTH)))
                    carrier_lock <= 1'b1;
            end
            if (r_vld_pipe[1]) r_prod <= w_prod;
            if (r_vld_pipe[2]) begin
                if (w_y < 0)                demod_data <= 12'd0;
                else if (w_y > 25'sd4095)   demod_data <= 12'd4095;
                else                        demod_data <= w_y[11:0];
            end
        end
    end

    assign demod_valid = r_vld_pipe[3];

endmodule

// File: tb/tb_fm_demod_zc.sv
// Directed bench for fm_demod_zc: sine tones of chosen period, a held input,
// sub-threshold noise and a reset pulse. A second instance with GAIN=128 shares
// the input and covers the upper saturation case.
module tb_fm_demod_zc;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] din;
    logic [11:0] demod_data,  demod_data2;
    logic        demod_valid, demod_valid2;
    logic        carrier_lock, carrier_lock2;
    logic [7:0]  period_out,  period_out2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cross_cyc = 0;
    int valid_cnt = 0;
    int last_lat = -1;
    int vbase;

    always #4 clk = ~clk;

    fm_demod_zc u_dut (
        .clk(clk), .rst(rst), .din(din),
        .demod_data(demod_data), .demod_valid(demod_valid),
        .carrier_lock(carrier_lock), .period_out(period_out)
    );

    fm_demod_zc #(.GAIN(128)) u_dut2 (
        .clk(clk), .rst(rst), .din(din),
        .demod_data(demod_data2), .demod_valid(demod_valid2),
        .carrier_lock(carrier_lock2), .period_out(period_out2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (demod_valid) begin
            valid_cnt <= valid_cnt + 1;
            last_lat  <= cyc - cross_cyc;
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // n whole periods of a full-scale sine with period p clks, starting at phase 0.
    task automatic drive_tone(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            for (int ph = 0; ph < p; ph++) begin
                @(posedge clk); #1;
                din = 12'(2048 + $rtoi(2000.0 * $sin(6.283185307 * ph / p)));
                if (ph == 1) cross_cyc = cyc + 1;
            end
        end
    endtask

    task automatic hold(input int v, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            din = 12'(v);
        end
    endtask

    task automatic noise(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            din = 12'(1998 + $urandom_range(0, 100));
        end
    endtask

    initial begin
        rst = 1'b0;
        din = 12'd2048;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  demod_data,   2047);
        chk("rst_valid", demod_valid,  0);
        chk("rst_lock",  carrier_lock, 0);
        chk("rst_per",   period_out,   0);
        #1 rst = 1'b1;

        // 1 MHz tone: arm + 3 periods gives nothing, the 4th accepted period gives a valid.
        drive_tone(120, 4);
        chk("t1_novalid", valid_cnt, 0);
        drive_tone(120, 1);
        chk("t1_first_valid", valid_cnt, 1);
        chk("t1_latency", last_lat, 4);
        chk("t1_data", demod_data, 2047);
        drive_tone(120, 3);
        chk("t1_lock_7", carrier_lock, 0);
        drive_tone(120, 1);
        chk("t1_lock_8", carrier_lock, 1);
        chk("t1_per", period_out, 120);

        // Steady deviation.
        drive_tone(100, 6);
        chk("t2_p100", demod_data, 3327);
        chk("t2_per", period_out, 100);
        chk("t2_lock", carrier_lock, 1);
        drive_tone(150, 6);
        chk("t2_p150", demod_data, 127);

        // Saturation at both ends.
        drive_tone(200, 6);
        chk("t3_p200_lo_sat", demod_data, 0);
        drive_tone(90, 6);
        chk("t3_p90_g64", demod_data, 3967);
        chk("t3_p90_hi_sat", demod_data2, 4095);

        // Carrier disappears: timeout after MAX_PERIOD clks.
        hold(2048, 100);
        chk("t4_lock_held", carrier_lock, 1);
        hold(2048, 200);
        chk("t4_lock_lost", carrier_lock, 0);
        chk("t4_data_mid", demod_data, 2047);

        // In-band noise never produces a rise event.
        vbase = valid_cnt;
        noise(500);
        chk("t5_noise_valid", valid_cnt - vbase, 0);
        chk("t5_noise_lock", carrier_lock, 0);
        drive_tone(120, 10);
        chk("t5_relock", carrier_lock, 1);
        // One 40-clk period: immediate loss, and that edge re-arms.
        drive_tone(40, 1);
        drive_tone(120, 1);
        chk("t5_short_lock", carrier_lock, 0);
        chk("t5_short_data", demod_data, 2047);
        vbase = valid_cnt;
        drive_tone(120, 4);
        chk("t5_rearm_valid", valid_cnt - vbase, 1);
        drive_tone(120, 5);
        chk("t5_relock2", carrier_lock, 1);

        // Reset pulse while locked.
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_during_data",  demod_data,   2047);
        chk("t6_during_valid", demod_valid,  0);
        chk("t6_during_lock",  carrier_lock, 0);
        chk("t6_during_per",   period_out,   0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_after_lock", carrier_lock, 0);
        chk("t6_after_per",  period_out,   0);
        drive_tone(120, 12);
        chk("t6_relock", carrier_lock, 1);
        chk("t6_data", demod_data, 2047);
        chk("t6_per", period_out, 120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
